// File: rtl/nx_ram_req_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nx_ram_req_ctrl_pkg
//   Shared constants and elaboration helpers for the RAM request controller
//   and its response FIFO. Holds no types; the blocks use plain logic ports.
// -----------------------------------------------------------------------------
package nx_ram_req_ctrl_pkg;

    // Widest data word the attached block RAM port supports.
    localparam int MAX_DATA_WIDTH = 36;

    // True when value is a non-zero power of two.
    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage : nx_ram_req_ctrl_pkg

// File: rtl/nx_fifo.sv
// -----------------------------------------------------------------------------
// nx_fifo
//   Small synchronous FIFO used as the read response buffer. The head entry
//   is presented combinationally on o_pop_data and reads as zero when empty,
//   so the consumer sees a clean zero out of reset.
//
// Ports
//   i_clk_a      clock
//   i_rst_a      asynchronous active-high reset, empties the FIFO
//   i_push       write i_push_data at the tail (ignored when full)
//   i_push_data  data to write
//   i_pop        drop the head entry (ignored when empty)
//   o_pop_data   head entry, zero when empty
//   o_full       DEPTH entries held
//   o_empty      no entries held
// -----------------------------------------------------------------------------
module nx_fifo
    import nx_ram_req_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             i_clk_a,
    input  logic             i_rst_a,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("nx_fifo: DEPTH must be a power of two and at least 2");
    end

    // One extra pointer bit distinguishes full from empty when the
    // index bits match.
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    assign o_pop_data = o_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge i_clk_a or posedge i_rst_a) begin
        if (i_rst_a) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, whatever order the statements appear in.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers define
    // which entries are meaningful and the output is masked while empty.
    always_ff @(posedge i_clk_a) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= i_push_data;
    end

endmodule : nx_fifo

// File: rtl/nx_ram_req_ctrl.sv
// -----------------------------------------------------------------------------
// nx_ram_req_ctrl
//   Request front end for one port of a block RAM. Requests are passed to
//   the RAM combinationally in the cycle they are accepted; read data is
//   captured into a response FIFO when it appears on the RAM output and is
//   returned in request order. A credit counter sized to the FIFO stops
//   accepting reads once every FIFO slot is spoken for, so the FIFO can
//   never overflow and no read ever has to be stalled inside the RAM.
//
// Ports
//   i_clk_a, i_rst_a     clock, asynchronous active-high reset
//   i_req_*/o_req_ready  request channel (valid/ready, write flag, addr, data)
//   o_rsp_*/i_rsp_ready  read response channel (valid/ready, data)
//   o_ram_*              RAM port A enable, write enable, address, write data
//   i_ram_rd_data        RAM port A read data
//   o_busy               reads in flight or responses buffered
// -----------------------------------------------------------------------------
module nx_ram_req_ctrl
    import nx_ram_req_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int REGISTER_RD   = 0,
    parameter int RSP_DEPTH     = 4
) (
    input  logic                     i_clk_a,
    input  logic                     i_rst_a,

    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
    input  logic                     i_req_write,
    input  logic [DATA_WIDTH-1:0]    i_req_wr_data,

    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA_WIDTH-1:0]    o_rsp_data,

    output logic                     o_ram_en,
    output logic                     o_ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0]    o_ram_wr_data,
    input  logic [DATA_WIDTH-1:0]    i_ram_rd_data,

    output logic                     o_busy
);

    // A read spends one cycle in the RAM array plus one more when the RAM
    // output register is enabled.
    localparam int PIPE_LEN = 1 + REGISTER_RD;
    localparam int CREDIT_W = $clog2(RSP_DEPTH) + 1;

    if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("nx_ram_req_ctrl: DATA_WIDTH must be 1..36");
    end
    if (REGISTER_RD != 0 && REGISTER_RD != 1) begin : g_bad_reg_rd
        $error("nx_ram_req_ctrl: REGISTER_RD must be 0 or 1");
    end

    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_d;
    logic [PIPE_LEN-1:0] pipe_q;
    logic [PIPE_LEN-1:0] pipe_d;

    logic req_hs;
    logic rd_hs;
    logic rsp_hs;
    logic fifo_push;
    logic fifo_full;
    logic fifo_empty;

    // Ready depends only on the credit register, never on the request inputs.
    assign o_req_ready = (credit_q != '0);

    assign req_hs = i_req_valid & o_req_ready;
    assign rd_hs  = req_hs & ~i_req_write;
    assign rsp_hs = o_rsp_valid & i_rsp_ready;

    assign o_ram_en      = req_hs;
    assign o_ram_wr_en   = req_hs & i_req_write;
    assign o_ram_addr    = i_req_addr;
    assign o_ram_wr_data = i_req_wr_data;

    // Credit tracks FIFO slots not yet claimed by an outstanding read.
    // Writes never produce a response, so they never spend credit.
    always_comb begin
        // NOTE: assigning the default first means every path writes
        // credit_d, so no latch is inferred.
        credit_d = credit_q;
        if (rd_hs && !rsp_hs) begin
            credit_d = credit_q - CREDIT_W'(1);
        end else if (!rd_hs && rsp_hs) begin
            credit_d = credit_q + CREDIT_W'(1);
        end
    end

    // Bit 0 marks a read issued last cycle; the top bit marks the cycle in
    // which that read's data sits on i_ram_rd_data.
    if (PIPE_LEN == 1) begin : g_pipe_short
        assign pipe_d = rd_hs;
    end else begin : g_pipe_long
        assign pipe_d = {pipe_q[PIPE_LEN-2:0], rd_hs};
    end

    always_ff @(posedge i_clk_a or posedge i_rst_a) begin
        if (i_rst_a) begin
            credit_q <= CREDIT_W'(RSP_DEPTH);
            pipe_q   <= '0;
        end else begin
            credit_q <= credit_d;
            pipe_q   <= pipe_d;
        end
    end

    assign fifo_push = pipe_q[PIPE_LEN-1];

    nx_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .i_clk_a     (i_clk_a),
        .i_rst_a     (i_rst_a),
        .i_push      (fifo_push),
        .i_push_data (i_ram_rd_data),
        .i_pop       (rsp_hs),
        .o_pop_data  (o_rsp_data),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    assign o_rsp_valid = ~fifo_empty;
    assign o_busy      = (|pipe_q) | ~fifo_empty;

    // The credit scheme makes this unreachable; firing means the credit
    // accounting and the FIFO depth have drifted apart.
    a_no_overflow : assert property (
        @(posedge i_clk_a) disable iff (i_rst_a) !(fifo_push && fifo_full)
    ) else $error("nx_ram_req_ctrl: push into full response FIFO");

endmodule : nx_ram_req_ctrl

// File: tb/tb_nx_ram_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nx_ram_req_ctrl
//   Two controllers share the clock: u_dut0 drives a plain RAM
//   (REGISTER_RD=0), u_dut1 a RAM with its output register enabled
//   (REGISTER_RD=1). A reference model per instance keeps a copy of the RAM
//   contents and a list of outstanding reads, each tagged with its data
//   and the first cycle its response may be presented.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nx_ram_req_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus (index = instance, instance k has REGISTER_RD = k)
    logic [1:0]         rst;
    logic [1:0]         req_valid;
    logic [1:0]         req_write;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wr_data;
    logic [1:0]         rsp_ready;

    // DUT outputs
    wire  [1:0]         req_ready;
    wire  [1:0]         rsp_valid;
    wire  [1:0][DW-1:0] rsp_data;
    wire  [1:0]         ram_en;
    wire  [1:0]         ram_wr_en;
    wire  [1:0][AW-1:0] ram_addr;
    wire  [1:0][DW-1:0] ram_wr_data;
    wire  [1:0]         busy;

    logic [DW-1:0] ram0_rd;
    logic [DW-1:0] ram1_raw;
    logic [DW-1:0] ram1_rd;

    nx_ram_req_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .REGISTER_RD(0), .RSP_DEPTH(DEPTH)) u_dut0 (
        .i_clk_a(clk), .i_rst_a(rst[0]),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_addr(req_addr[0]),
        .i_req_write(req_write[0]), .i_req_wr_data(req_wr_data[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_data(rsp_data[0]),
        .o_ram_en(ram_en[0]), .o_ram_wr_en(ram_wr_en[0]), .o_ram_addr(ram_addr[0]),
        .o_ram_wr_data(ram_wr_data[0]), .i_ram_rd_data(ram0_rd), .o_busy(busy[0])
    );

    nx_ram_req_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .REGISTER_RD(1), .RSP_DEPTH(DEPTH)) u_dut1 (
        .i_clk_a(clk), .i_rst_a(rst[1]),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_addr(req_addr[1]),
        .i_req_write(req_write[1]), .i_req_wr_data(req_wr_data[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_data(rsp_data[1]),
        .o_ram_en(ram_en[1]), .o_ram_wr_en(ram_wr_en[1]), .o_ram_addr(ram_addr[1]),
        .o_ram_wr_data(ram_wr_data[1]), .i_ram_rd_data(ram1_rd), .o_busy(busy[1])
    );

    // Block RAM models: read-first port, optional output register.
    logic [DW-1:0] ram0 [1<<AW];
    logic [DW-1:0] ram1 [1<<AW];

    always @(posedge clk) begin
        if (ram_en[0]) begin
            if (ram_wr_en[0]) ram0[ram_addr[0]] <= ram_wr_data[0];
            else              ram0_rd <= ram0[ram_addr[0]];
        end
    end

    always @(posedge clk) begin
        if (ram_en[1]) begin
            if (ram_wr_en[1]) ram1[ram_addr[1]] <= ram_wr_data[1];
            else              ram1_raw <= ram1[ram_addr[1]];
        end
        ram1_rd <= ram1_raw;
    end

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ------------------------------------------------------- reference model
    logic [DW-1:0] mdl_mem [2][16];
    logic [DW-1:0] e_data  [2][64];
    int            e_cyc   [2][64];
    int            head    [2];
    int            tail    [2];
    int            pops    [2];
    int            rises   [2];
    int            last_rise [2];
    logic [DW-1:0] rise_data [2];
    logic          prev_vld  [2];

    // All outputs are sampled at the falling edge; requests and pops seen
    // here take effect at the next rising edge.
    always @(negedge clk) begin
        int   outst;
        int   slot;
        logic exp_rdy;
        logic exp_en;
        logic exp_vld;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                check($sformatf("u%0d_rst_ready", k), req_ready[k], 1);
                check($sformatf("u%0d_rst_rsp_valid", k), rsp_valid[k], 0);
                check($sformatf("u%0d_rst_rsp_data", k), rsp_data[k], 0);
                check($sformatf("u%0d_rst_busy", k), busy[k], 0);
                head[k]     = 0;
                tail[k]     = 0;
                prev_vld[k] = 1'b0;
            end else begin
                outst   = tail[k] - head[k];
                exp_rdy = (outst < DEPTH);
                exp_en  = req_valid[k] & exp_rdy;
                slot    = head[k] % 64;
                exp_vld = (outst != 0) && (e_cyc[k][slot] <= cyc);

                check($sformatf("u%0d_ready", k), req_ready[k], exp_rdy);
                check($sformatf("u%0d_busy", k), busy[k], outst != 0);
                check($sformatf("u%0d_ram_en", k), ram_en[k], exp_en);
                check($sformatf("u%0d_ram_wr_en", k), ram_wr_en[k], exp_en & req_write[k]);
                if (exp_en) begin
                    check($sformatf("u%0d_ram_addr", k), ram_addr[k], req_addr[k]);
                    if (req_write[k])
                        check($sformatf("u%0d_ram_wr_data", k), ram_wr_data[k], req_wr_data[k]);
                end
                check($sformatf("u%0d_rsp_valid", k), rsp_valid[k], exp_vld);
                if (exp_vld)
                    check($sformatf("u%0d_rsp_data", k), rsp_data[k], e_data[k][slot]);

                if (rsp_valid[k] && !prev_vld[k]) begin
                    rises[k]++;
                    last_rise[k] = cyc;
                    rise_data[k] = rsp_data[k];
                end
                prev_vld[k] = rsp_valid[k];

                if (exp_vld && rsp_ready[k]) begin
                    head[k]++;
                    pops[k]++;
                end
                if (exp_en) begin
                    if (req_write[k]) begin
                        mdl_mem[k][req_addr[k][3:0]] = req_wr_data[k];
                    end else begin
                        e_data[k][tail[k] % 64] = mdl_mem[k][req_addr[k][3:0]];
                        e_cyc[k][tail[k] % 64]  = cyc + 2 + k;
                        tail[k]++;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- driving
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted or budget cycles pass.
    task automatic do_req(input int k, input bit wr, input int addr, input logic [DW-1:0] data,
                          input int budget, output bit acc, output int acc_cyc, output int waits);
        req_valid[k]   = 1'b1;
        req_write[k]   = wr;
        req_addr[k]    = AW'(addr);
        req_wr_data[k] = data;
        acc     = 1'b0;
        acc_cyc = -1;
        waits   = 0;
        while (!acc && waits < budget) begin
            @(negedge clk);
            if (req_ready[k]) begin
                acc     = 1'b1;
                acc_cyc = cyc;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit acc;
        int c;
        int c0;
        int w;
        int n_acc;
        int p0;
        int r0;

        for (int k = 0; k < 2; k++) begin
            head[k] = 0; tail[k] = 0; pops[k] = 0; rises[k] = 0;
            last_rise[k] = -1; rise_data[k] = '0; prev_vld[k] = 1'b0;
        end
        rst = '1; req_valid = '0; req_write = '0; req_addr = '0; req_wr_data = '0; rsp_ready = '1;
        tick(3);
        rst = '0;
        tick(1);

        // Give every address the bench uses a known value in both RAMs.
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 16; a++) begin
                do_req(k, 1'b1, a, $urandom, 8, acc, c, w);
                check("preload_acc", acc, 1);
            end
            req_valid[k] = 1'b0;
        end
        tick(2);

        // Write then read the same word, plain RAM: response two cycles later.
        do_req(0, 1'b1, 5, 32'hDEADBEEF, 8, acc, c, w);
        p0 = pops[0];
        do_req(0, 1'b0, 5, '0, 8, acc, c, w);
        req_valid[0] = 1'b0;
        tick(5);
        check("s1_rise_cycle", last_rise[0], c + 2);
        check("s1_rsp_data", rise_data[0], 32'hDEADBEEF);
        check("s1_pops", pops[0] - p0, 1);

        // Registered RAM: eight back-to-back reads of word k holding k.
        for (int i = 0; i < 8; i++) do_req(1, 1'b1, i, DW'(i), 8, acc, c, w);
        req_valid[1] = 1'b0;
        tick(2);
        p0 = pops[1];
        r0 = rises[1];
        c0 = 0;
        for (int i = 0; i < 8; i++) begin
            do_req(1, 1'b0, i, '0, 8, acc, c, w);
            if (i == 0) c0 = c;
            check($sformatf("s2_stall_%0d", i), w, 0);
        end
        req_valid[1] = 1'b0;
        tick(8);
        check("s2_first_rise", last_rise[1], c0 + 3);
        check("s2_first_data", rise_data[1], 0);
        check("s2_one_burst", rises[1] - r0, 1);
        check("s2_pops", pops[1] - p0, 8);

        // Stalled consumer: only DEPTH reads fit, then a write is refused too.
        rsp_ready[0] = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            do_req(0, 1'b0, i, '0, 4, acc, c, w);
            n_acc += int'(acc);
        end
        check("s3_accepted", n_acc, 4);
        req_write[0] = 1'b1;
        @(negedge clk);
        check("s3_ready_low", req_ready[0], 0);
        check("s4_wr_ram_en", ram_en[0], 0);
        check("s4_wr_ram_wr_en", ram_wr_en[0], 0);
        tick(1);
        req_valid[0] = 1'b0;
        req_write[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        tick(1);
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        check("s3_ready_back", req_ready[0], 1);
        tick(1);
        rsp_ready[0] = 1'b1;
        tick(8);
        @(negedge clk);
        check("s3_drained_busy", busy[0], 0);
        tick(1);

        // Reset one cycle after a read handshake: that read never answers.
        p0 = pops[0];
        r0 = rises[0];
        do_req(0, 1'b0, 3, '0, 8, acc, c, w);
        rst[0] = 1'b1;
        req_valid[0] = 1'b0;
        tick(1);
        rst[0] = 1'b0;
        tick(8);
        check("s5_no_rsp_pops", pops[0] - p0, 0);
        check("s5_no_rsp_rises", rises[0] - r0, 0);
        @(negedge clk);
        check("s5_busy", busy[0], 0);
        check("s5_ready", req_ready[0], 1);
        tick(1);

        // Pop and read handshake in the same cycle leave credit unchanged.
        rsp_ready[0] = 1'b0;
        do_req(0, 1'b0, 1, '0, 8, acc, c, w);
        do_req(0, 1'b0, 2, '0, 8, acc, c, w);
        req_valid[0] = 1'b0;
        tick(3);
        rsp_ready[0] = 1'b1;
        do_req(0, 1'b0, 3, '0, 8, acc, c, w);
        check("s6_concurrent_acc", acc, 1);
        rsp_ready[0] = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b0, 4 + i, '0, 4, acc, c, w);
            n_acc += int'(acc);
        end
        check("s6_credit_left", n_acc, 2);
        req_valid[0] = 1'b0;
        p0 = pops[0];
        rsp_ready[0] = 1'b1;
        tick(10);
        check("s6_pops", pops[0] - p0, 4);

        // Random traffic on both instances; the model checks every cycle.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                req_valid[k]   = 1'($urandom_range(0, 1));
                req_write[k]   = ($urandom_range(0, 2) == 0);
                req_addr[k]    = AW'($urandom_range(0, 15));
                req_wr_data[k] = $urandom;
                rsp_ready[k]   = ($urandom_range(0, 3) != 0);
            end
            tick(1);
        end
        req_valid = '0;
        rsp_ready = '1;
        tick(12);
        @(negedge clk);
        check("final_busy0", busy[0], 0);
        check("final_busy1", busy[1], 0);
        check("final_ready0", req_ready[0], 1);
        check("final_ready1", req_ready[1], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_nx_ram_req_ctrl

// File: doc/nx_ram_req_ctrl.md
NX_RAM_REQ_CTRL -- requirements
Module: nx_ram_req_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 10: RAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: RAM data width, maximum 36.
REQ-003 SHALL have parameter REGISTER_RD, default 0: 1 when the attached RAM port has its output register enabled.
REQ-004 SHALL have parameter RSP_DEPTH, default 4: response buffer entries, power of two, minimum 2.
REQ-005 SHALL have port i_clk_a, input, 1 bit: clock.
REQ-006 SHALL have port i_rst_a, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port i_req_valid, input, 1 bit: request valid.
REQ-008 SHALL have port o_req_ready, output, 1 bit: request accepted this cycle when also valid.
REQ-009 SHALL have port i_req_addr, input, ADDRESS_WIDTH: word address.
REQ-010 SHALL have port i_req_write, input, 1 bit: 1 is write, 0 is read.
REQ-011 SHALL have port i_req_wr_data, input, DATA_WIDTH: write data.
REQ-012 SHALL have port o_rsp_valid, input/output pair: o_rsp_valid output, 1 bit, read response valid.
REQ-013 SHALL have port i_rsp_ready, input, 1 bit: response consumer ready.
REQ-014 SHALL have port o_rsp_data, output, DATA_WIDTH: read response data.
REQ-015 SHALL have ports o_ram_en, o_ram_wr_en (output, 1 bit each), o_ram_addr (output, ADDRESS_WIDTH) and o_ram_wr_data (output, DATA_WIDTH): RAM port A drive.
REQ-016 SHALL have port i_ram_rd_data, input, DATA_WIDTH: RAM port A read data.
REQ-017 SHALL have port o_busy, output, 1 bit: reads in flight or responses buffered.

Function
REQ-018 SHALL define a request handshake as i_req_valid and o_req_ready both high on a rising edge.
REQ-019 SHALL drive o_req_ready from registered state only, with no dependency on any request input.
REQ-020 SHALL assert o_req_ready exactly when the credit counter is non-zero.
REQ-021 SHALL keep a credit counter initialised to RSP_DEPTH: decrement on read handshake, increment on response handshake, unchanged when both occur in the same cycle.
REQ-022 SHALL consume credit on write handshakes: never.
REQ-023 SHALL drive o_ram_en = i_req_valid & o_req_ready, o_ram_wr_en = o_ram_en & i_req_write, and o_ram_addr/o_ram_wr_data = i_req_addr/i_req_wr_data, all combinationally.
REQ-024 SHALL track in-flight reads with a valid shift pipe of length 1+REGISTER_RD; the pipe output marks the cycle in which i_ram_rd_data holds that read's data.
REQ-025 SHALL push i_ram_rd_data into the response FIFO on the pipe-output cycle; for a read handshake in cycle N, o_rsp_valid rises no earlier than cycle N+2+REGISTER_RD.
REQ-026 SHALL return responses strictly in request order.
REQ-027 SHALL hold o_rsp_data stable while o_rsp_valid is high and i_rsp_ready is low.
REQ-028 SHALL never overflow the FIFO, guaranteed by the credit scheme; a push into a full FIFO is an assertion failure.
REQ-029 SHALL sustain one request per cycle, including back-to-back reads, while credit remains.
REQ-030 SHALL produce no response for writes; a write to address A issued after a read of A leaves that read's data unaffected.
REQ-031 SHALL drive o_busy = (pipe non-empty) | (FIFO non-empty).

Reset
REQ-032 SHALL on i_rst_a clear the pipe and FIFO and set the credit counter to RSP_DEPTH, immediately and asynchronously.
REQ-033 SHALL have reset values o_req_ready=1, o_rsp_valid=0, o_rsp_data=0 and o_busy=0.
REQ-034 SHALL discard reads in flight when reset is asserted mid-operation, producing no response for them after reset.

Structure
REQ-035 SHALL place no new typedefs in a shared package; pipe length 1+REGISTER_RD is a localparam.
REQ-036 SHALL implement the response buffer as one sub-module, nx_fifo, with parameters DEPTH and WIDTH and push/pop/full/empty ports.

Verification
REQ-037 SHALL cover: REGISTER_RD=0, write 0xDEADBEEF to addr 5 then read addr 5 -> response 0xDEADBEEF, o_rsp_valid at read cycle+2.
REQ-038 SHALL cover: REGISTER_RD=1, 8 back-to-back reads of addrs 0..7 preloaded with k, i_rsp_ready=1 -> responses 0..7 in order, first at issue+3, no ready stall.
REQ-039 SHALL cover: RSP_DEPTH=4, i_rsp_ready=0, 6 reads -> exactly 4 accepted, o_req_ready=0 after the 4th; one pop then re-asserts ready the next cycle.
REQ-040 SHALL cover: with zero credit, a write attempt -> not accepted and o_ram_en=0.
REQ-041 SHALL cover: reset pulsed one cycle after a read handshake -> no response ever, o_busy=0, o_req_ready=1.
REQ-042 SHALL cover: a response pop and a read handshake in the same cycle -> credit count unchanged and ordering preserved.
